// File: rtl/pipe_scheduler.sv
// Pipe obstacle scheduler: scrolls three pipes left on each frame tick through one
// shared adder (one pipe per cycle), respawns off-screen pipes and flags bird passes.
module pipe_scheduler #(
    parameter int START_X = 640,
    parameter int SPACING = 224,
    parameter int PIPE_W  = 52,
    parameter int BIRD_X  = 160,
    parameter int GAP_MIN = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        run,
    input  logic        mode,
    output logic [31:0] pipe1,
    output logic [31:0] pipe2,
    output logic [31:0] pipe3,
    output logic        pass_pulse,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    typedef enum logic [2:0] {IDLE, UPD0, UPD1, UPD2, DONE} state_t;

    localparam logic signed [15:0] L_START  = 16'(START_X);
    localparam logic signed [15:0] L_SPACE  = 16'(SPACING);
    localparam logic signed [15:0] L_WRAP   = 16'(3 * SPACING);
    localparam logic signed [15:0] L_PW     = 16'(PIPE_W);
    localparam logic signed [15:0] L_NEG_PW = 16'(-PIPE_W);
    localparam logic signed [15:0] L_BIRD   = 16'(BIRD_X);
    localparam logic        [15:0] L_GAP    = 16'(GAP_MIN);
    localparam logic        [15:0] L_GAP0   = 16'(GAP_MIN + 128);
    localparam logic        [15:0] L_SEED   = 16'hACE1;

    state_t             r_state;
    logic signed [15:0] r_x [3];
    logic        [15:0] r_gap [3];
    logic        [15:0] r_lfsr;
    logic signed [15:0] r_spd;
    logic               r_pass;
    logic               r_busy;
    logic               r_done;
    logic               r_overrun;

    logic signed [15:0] w_curX;
    logic signed [15:0] w_nx;
    logic signed [15:0] w_nextX;
    logic               w_respawn;
    logic               w_pass;
    logic               w_upd;
    logic               w_lfsrFb;
    logic        [15:0] w_newGap;

    // The single shared adder works on whichever pipe the current UPD state selects
    always_comb begin
        w_curX = r_x[0];
        w_upd  = 1'b0;
        case (r_state)
            UPD0: begin w_curX = r_x[0]; w_upd = 1'b1; end
            UPD1: begin w_curX = r_x[1]; w_upd = 1'b1; end
            UPD2: begin w_curX = r_x[2]; w_upd = 1'b1; end
            default: ;
        endcase
    end

    assign w_nx      = w_curX - r_spd;
    assign w_respawn = (w_nx <= L_NEG_PW);
    assign w_nextX   = w_respawn ? (w_nx + L_WRAP) : w_nx;
    // Pass uses the pre-respawn position so a wrapping pipe cannot fake a crossing
    assign w_pass    = ((w_curX + L_PW) > L_BIRD) && ((w_nx + L_PW) <= L_BIRD);
    assign w_lfsrFb  = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_newGap  = L_GAP + {8'd0, r_lfsr[7:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_x[0]    <= L_START;
            r_x[1]    <= L_START + L_SPACE;
            r_x[2]    <= L_START + L_SPACE + L_SPACE;
            r_gap[0]  <= L_GAP0;
            r_gap[1]  <= L_GAP0;
            r_gap[2]  <= L_GAP0;
            r_lfsr    <= L_SEED;
            r_spd     <= 16'sd2;
            r_pass    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_lfsr <= {w_lfsrFb, r_lfsr[15:1]};
            r_pass <= w_upd && w_pass;
            r_done <= 1'b0;
            if (frame_tick && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (frame_tick && run) begin
                        r_state <= UPD0;
                        r_busy  <= 1'b1;
                        r_spd   <= mode ? 16'sd4 : 16'sd2;
                    end
                end
                UPD0: begin
                    r_x[0] <= w_nextX;
                    if (w_respawn) r_gap[0] <= w_newGap;
                    r_state <= UPD1;
                end
                UPD1: begin
                    r_x[1] <= w_nextX;
                    if (w_respawn) r_gap[1] <= w_newGap;
                    r_state <= UPD2;
                end
                UPD2: begin
                    r_x[2] <= w_nextX;
                    if (w_respawn) r_gap[2] <= w_newGap;
                    r_state <= DONE;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pipe1      = {r_x[0], r_gap[0]};
    assign pipe2      = {r_x[1], r_gap[1]};
    assign pipe3      = {r_x[2], r_gap[2]};
    assign pass_pulse = r_pass;
    assign busy       = r_busy;
    assign done       = r_done;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed bench for pipe_scheduler: per-feature tasks with hand-derived positions
// and a small reference model for pipe motion, pass detection and the LFSR gap draw.
module tb_pipe_scheduler;

    logic        clk;
    logic        rst;
    logic        frame_tick;
    logic        run;
    logic        mode;
    logic [31:0] pipe1;
    logic [31:0] pipe2;
    logic [31:0] pipe3;
    logic        pass_pulse;
    logic        busy;
    logic        done;
    logic        overrun;

    int testsRun    = 0;
    int testsFailed = 0;
    int passSeen    = 0;

    int          mx [3];
    int          mg [3];
    logic        mOverrun;
    logic [15:0] mLfsr;

    pipe_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .run        (run),
        .mode       (mode),
        .pipe1      (pipe1),
        .pipe2      (pipe2),
        .pipe3      (pipe3),
        .pass_pulse (pass_pulse),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR, free-running from reset exactly like the game's random source
    always @(posedge clk) begin
        if (rst) mLfsr <= 16'hACE1;
        else     mLfsr <= {mLfsr[0] ^ mLfsr[2] ^ mLfsr[3] ^ mLfsr[5], mLfsr[15:1]};
    end

    function automatic logic [31:0] getWord(input int k);
        case (k)
            0:       return pipe1;
            1:       return pipe2;
            default: return pipe3;
        endcase
    endfunction

    function automatic int getX(input int k);
        logic [31:0] w;
        w = getWord(k);
        return int'($signed(w[31:16]));
    endfunction

    task automatic applyReset();
        rst = 1'b1;
        frame_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mx[0] = 640; mx[1] = 864; mx[2] = 1088;
        mg[0] = 188; mg[1] = 188; mg[2] = 188;
        mOverrun = 1'b0;
    endtask

    // One full update sequence, checking each pipe the cycle it becomes visible
    task automatic applyTick(input logic modeVal, input logic modeLater, input logic extraTick);
        int spdM, nx;
        logic expPass;
        logic [15:0] lf;
        @(negedge clk);
        mode = modeVal; run = 1'b1; frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        spdM = modeVal ? 4 : 2;
        testsRun++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL seq_start busy=%b done=%b required busy=1 done=0", busy, done);
        end
        for (int k = 0; k < 3; k++) begin
            lf = mLfsr;
            nx = mx[k] - spdM;
            expPass = ((mx[k] + 52) > 160) && ((nx + 52) <= 160);
            if (nx <= -52) begin
                mx[k] = nx + 672;
                mg[k] = 60 + int'(lf[7:0]);
            end else begin
                mx[k] = nx;
            end
            @(posedge clk); #1;
            if (pass_pulse === 1'b1) passSeen++;
            testsRun++;
            if (getX(k) !== mx[k] || int'(getWord(k) & 32'hFFFF) !== mg[k]) begin
                testsFailed++;
                $display("[TB] FAIL pipe%0d_update got x=%0d gap=%0d required x=%0d gap=%0d",
                         k + 1, getX(k), getWord(k) & 32'hFFFF, mx[k], mg[k]);
            end
            testsRun++;
            if (pass_pulse !== expPass || busy !== 1'b1 || done !== (k == 2)) begin
                testsFailed++;
                $display("[TB] FAIL flags_step%0d got pass=%b busy=%b done=%b required pass=%b busy=1 done=%b",
                         k, pass_pulse, busy, done, expPass, (k == 2));
            end
            testsRun++;
            if (overrun !== mOverrun) begin
                testsFailed++;
                $display("[TB] FAIL overrun_step%0d got %b required %b", k, overrun, mOverrun);
            end
            if (k == 0) begin
                if (modeLater) mode = ~modeVal;
                if (extraTick) begin
                    frame_tick = 1'b1;
                    mOverrun = 1'b1;
                end
            end
            if (k == 1) frame_tick = 1'b0;
        end
        @(posedge clk); #1;
        testsRun++;
        if (busy !== 1'b0 || done !== 1'b0 || pass_pulse !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL seq_end got busy=%b done=%b pass=%b required 0 0 0", busy, done, pass_pulse);
        end
    endtask

    task automatic test_reset();
        applyReset();
        repeat (3) begin
            testsRun++;
            if (pipe1 !== 32'h0280_00BC || pipe2 !== 32'h0360_00BC || pipe3 !== 32'h0440_00BC) begin
                testsFailed++;
                $display("[TB] FAIL reset_pipes got %h %h %h required 028000bc 036000bc 044000bc",
                         pipe1, pipe2, pipe3);
            end
            testsRun++;
            if ({busy, done, pass_pulse, overrun} !== 4'b0000) begin
                testsFailed++;
                $display("[TB] FAIL reset_flags got %b required 0000", {busy, done, pass_pulse, overrun});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single_tick();
        applyTick(1'b0, 1'b0, 1'b0);
        testsRun++;
        if (getX(0) !== 638 || getX(1) !== 862 || getX(2) !== 1086) begin
            testsFailed++;
            $display("[TB] FAIL single_tick got %0d %0d %0d required 638 862 1086", getX(0), getX(1), getX(2));
        end
    endtask

    task automatic test_run_low();
        logic sawBusy;
        sawBusy = 1'b0;
        @(negedge clk);
        run = 1'b0; mode = 1'b0; frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        repeat (6) begin
            if (busy !== 1'b0 || done !== 1'b0) sawBusy = 1'b1;
            @(posedge clk); #1;
        end
        testsRun++;
        if (sawBusy !== 1'b0 || getX(0) !== 638 || getX(1) !== 862 || getX(2) !== 1086) begin
            testsFailed++;
            $display("[TB] FAIL run_low busyseen=%b x=%0d %0d %0d required 0 638 862 1086",
                     sawBusy, getX(0), getX(1), getX(2));
        end
        run = 1'b1;
    endtask

    task automatic test_speed_latch();
        applyTick(1'b0, 1'b1, 1'b0);
        testsRun++;
        if (getX(0) !== 636 || getX(1) !== 860 || getX(2) !== 1084) begin
            testsFailed++;
            $display("[TB] FAIL mode_latched got %0d %0d %0d required 636 860 1084", getX(0), getX(1), getX(2));
        end
        applyTick(1'b1, 1'b0, 1'b0);
        testsRun++;
        if (getX(0) !== 632 || getX(1) !== 856 || getX(2) !== 1080) begin
            testsFailed++;
            $display("[TB] FAIL mode_fast got %0d %0d %0d required 632 856 1080", getX(0), getX(1), getX(2));
        end
    endtask

    task automatic test_overrun();
        applyTick(1'b0, 1'b0, 1'b1);
        testsRun++;
        if (getX(0) !== 630 || getX(1) !== 854 || getX(2) !== 1078 || overrun !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL overrun_seq got %0d %0d %0d ovr=%b required 630 854 1078 ovr=1",
                     getX(0), getX(1), getX(2), overrun);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mode = 1'b0; run = 1'b1; frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        testsRun++;
        if (pipe1 !== 32'h0280_00BC || pipe2 !== 32'h0360_00BC || pipe3 !== 32'h0440_00BC ||
            {busy, done, pass_pulse, overrun} !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid got %h %h %h flags=%b required 028000bc 036000bc 044000bc flags=0000",
                     pipe1, pipe2, pipe3, {busy, done, pass_pulse, overrun});
        end
        mx[0] = 640; mx[1] = 864; mx[2] = 1088;
        mg[0] = 188; mg[1] = 188; mg[2] = 188;
        mOverrun = 1'b0;
        @(posedge clk); #1;
        testsRun++;
        if (busy !== 1'b0 || getX(0) !== 640) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_hold got busy=%b x=%0d required busy=0 x=640", busy, getX(0));
        end
        applyTick(1'b0, 1'b0, 1'b0);
        testsRun++;
        if (getX(0) !== 638) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_idle got x=%0d required 638", getX(0));
        end
    endtask

    task automatic test_pass();
        applyReset();
        passSeen = 0;
        repeat (265) applyTick(1'b0, 1'b0, 1'b0);
        testsRun++;
        if (getX(0) !== 110 || passSeen !== 0) begin
            testsFailed++;
            $display("[TB] FAIL pass_approach got x=%0d pulses=%0d required x=110 pulses=0", getX(0), passSeen);
        end
        applyTick(1'b0, 1'b0, 1'b0);
        testsRun++;
        if (getX(0) !== 108 || passSeen !== 1) begin
            testsFailed++;
            $display("[TB] FAIL pass_cross got x=%0d pulses=%0d required x=108 pulses=1", getX(0), passSeen);
        end
        applyTick(1'b0, 1'b0, 1'b0);
        testsRun++;
        if (getX(0) !== 106 || passSeen !== 1) begin
            testsFailed++;
            $display("[TB] FAIL pass_after got x=%0d pulses=%0d required x=106 pulses=1", getX(0), passSeen);
        end
    endtask

    task automatic test_respawn();
        repeat (39) applyTick(1'b1, 1'b0, 1'b0);
        testsRun++;
        if (getX(0) !== -50 || pipe1[15:0] !== 16'd188) begin
            testsFailed++;
            $display("[TB] FAIL respawn_edge got x=%0d gap=%0d required x=-50 gap=188", getX(0), pipe1[15:0]);
        end
        applyTick(1'b1, 1'b0, 1'b0);
        testsRun++;
        if (getX(0) !== 618 || int'(pipe1[15:0]) !== mg[0] || passSeen !== 1) begin
            testsFailed++;
            $display("[TB] FAIL respawn got x=%0d gap=%0d pulses=%0d required x=618 gap=%0d pulses=1",
                     getX(0), pipe1[15:0], passSeen, mg[0]);
        end
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0; run = 1'b0; mode = 1'b0;
        test_reset();
        test_single_tick();
        test_run_low();
        test_speed_latch();
        test_overrun();
        test_reset_mid();
        test_pass();
        test_respawn();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/pipe_scheduler.md
# pipe_scheduler

Sequences the three pipe obstacles that feed the `pipe1`/`pipe2`/`pipe3` words consumed by `display`. On each frame tick it scrolls the pipes left through one shared adder, processing one pipe per cycle. It respawns pipes that have left the screen with a pseudo-random gap, and emits a pass pulse that the game `control` logic uses for scoring. It sits between the frame-timing source and the `control`/`display` pair.

## Interface
Parameters:
- `START_X`, 640: x of pipe1 after reset.
- `SPACING`, 224: horizontal distance between consecutive pipes.
- `PIPE_W`, 52: pipe width in pixels.
- `BIRD_X`, 160: fixed bird x used for pass detection.
- `GAP_MIN`, 60: minimum gap-top y.

Ports:
- `clk` input 1: system clock. One clock domain.
- `rst` input 1: synchronous, active-high reset.
- `frame_tick` input 1: one-cycle pulse, once per video frame.
- `run` input 1: high while the game is in the playing status. Ticks are ignored while low.
- `mode` input 1: speed select. 0 = 2 px/frame, 1 = 4 px/frame.
- `pipe1`, `pipe2`, `pipe3` output 32 each: `{x[15:0] signed two's complement, gap_top[15:0] unsigned}`.
- `pass_pulse` output 1: one-cycle pulse when a pipe's trailing edge crosses `BIRD_X`.
- `busy` output 1: high while an update sequence is in progress.
- `done` output 1: one-cycle pulse when an update sequence completes.
- `overrun` output 1: sticky flag. Set when `frame_tick` arrives while not IDLE; cleared only by `rst`.

## Operation
- State machine: IDLE -> UPD0 -> UPD1 -> UPD2 -> DONE -> IDLE.
  - IDLE -> UPD0 on `frame_tick & run`. Otherwise IDLE holds.
  - UPDk updates pipe k+1. DONE always returns to IDLE.
- `mode` is latched into the speed register `spd` (2 or 4) on the IDLE -> UPD0 transition. It is held for the whole sequence.
- Per UPDk: `nx = x - spd` (16-bit signed).
  - If `nx <= -PIPE_W`: respawn. Set `x <= nx + 3*SPACING` and `gap_top <= GAP_MIN + lfsr[7:0]`.
  - Else set `x <= nx`; gap_top is unchanged.
- Pass detection per UPDk:
  - Condition: `(x + PIPE_W > BIRD_X) && (nx + PIPE_W <= BIRD_X)`, evaluated signed on the pre-respawn `nx`.
  - On match, `pass_pulse` is registered high for the cycle after UPDk.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, seed 0xACE1. Advances every clock, including during reset release, so sequences are deterministic from reset.
- `run` falling mid-sequence does not abort: the sequence completes.
- `frame_tick` while not IDLE is dropped and sets `overrun`.
- Reset values, applied on any cycle including mid-sequence:
  - state = IDLE.
  - `pipe1` = `{START_X, GAP_MIN+128}`.
  - `pipe2` = `{START_X+SPACING, GAP_MIN+128}`.
  - `pipe3` = `{START_X+2*SPACING, GAP_MIN+128}`.
  - `pass_pulse` = `busy` = `done` = `overrun` = 0.
  - `lfsr` = 0xACE1.
  - `spd` = 2.

## Timing
- `frame_tick` sampled high at edge T:
  - UPD0 during cycle T+1. `pipe1` new value visible from T+2.
  - `pipe2` visible from T+3; `pipe3` visible from T+4.
  - DONE during T+4, so `done` is high for T+4 only.
  - `busy` is high T+1..T+4.
- Total latency from tick to all pipes updated: 4 cycles. A new tick is accepted from T+5.
- `pass_pulse` is coincident with the cycle the corresponding updated pipe word first becomes visible.
- Only one pipe can pass per frame, since `SPACING` > max speed. `pass_pulse` never exceeds one pulse per sequence.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset, then hold: `pipe1`=`{640,188}`, `pipe2`=`{864,188}`, `pipe3`=`{1088,188}`. `busy`/`done`/`pass_pulse`/`overrun`=0.
- One tick with mode=0, run=1:
  - x becomes 638, 862, 1086 at T+2, T+3, T+4 respectively.
  - `done` is high only at T+4.
  - The same tick with run=0 gives no change.
- Force pipe1 x=-51 with mode=0 and tick:
  - x becomes 619 (-53 + 672).
  - gap_top = 60 + lfsr[7:0] sampled in UPD0, checked against the reference LFSR model.
- pipe1 x=109, mode=0, tick:
  - x becomes 107 and `pass_pulse` is high one cycle at T+2.
  - pipe1 x=107 then ticked to 105: no pulse.
- Overrun and reset:
  - Second tick at T+2: ignored, `overrun`=1 from T+3, sequence finishes normally.
  - `rst` at T+2: all outputs return to reset values at T+3 and state is IDLE.
- mode toggled 0->1 at T+2 during a sequence: all three pipes still move 2 px. The next tick moves them 4 px.
